// File: rtl/gate_seq_ctrl_pkg.sv
// Shared definitions for the gate truth-table sweep controller and its bench.
package gate_seq_ctrl_pkg;

    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/gate_seq_ctrl_settle_cnt.sv
// Settle counter: cleared by load, counts while enabled, flags the terminal count.
module settle_cnt
    import gate_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal only while counting, so the flag marks the last settle cycle.
    assign tc_c = en && (count == term);

endmodule

// File: rtl/gate_seq_ctrl.sv
// Drives the four input vectors of an external 2-input gate, waits for it to
// settle, samples its output and compares against a latched truth table.
module gate_seq_ctrl
    import gate_seq_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] exp_tt,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask
);

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [NUM_VEC-1:0]        exp_q;
    logic [NUM_VEC-1:0]        hit_c;
    logic                      cnt_load_c;
    logic                      cnt_en_c;
    logic                      cnt_tc_c;

    assign cnt_load_c = (state == ST_APPLY);
    assign cnt_en_c   = (state == ST_WAIT);

    settle_cnt u_settle_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load_c),
        .en   (cnt_en_c),
        .term (CNT_W'(SETTLE - 1)),
        .tc_c (cnt_tc_c)
    );

    // Mismatch bit for the vector currently being sampled.
    always_comb begin
        hit_c      = '0;
        hit_c[idx] = y ^ exp_q[idx];
    end

    // {a,b} are loaded on the edge entering APPLY so each vector is visible
    // for the whole APPLY+WAIT+SAMPLE window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            exp_q    <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_mask <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        exp_q    <= exp_tt;
                        err_mask <= '0;
                        pass     <= 1'b0;
                        idx      <= '0;
                        {a, b}   <= 2'b00;
                        busy     <= 1'b1;
                        state    <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_tc_c) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    err_mask <= err_mask | hit_c;
                    if (idx == IDX_W'(NUM_VEC - 1)) begin
                        pass   <= ((err_mask | hit_c) == 4'd0);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        {a, b} <= 2'b00;
                        state  <= ST_DONE;
                    end else begin
                        idx    <= idx + IDX_W'(1);
                        {a, b} <= idx + IDX_W'(1);
                        state  <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Scoreboard bench for gate_seq_ctrl: behavioural gate models, expected sweep
// results queued at start and compared when done pulses.
module tb_gate_seq_ctrl;
    import gate_seq_ctrl_pkg::*;

    typedef struct {
        int unsigned cyc;
        logic        pass;
        logic [3:0]  mask;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 0: SETTLE=2
    logic rst0, start0, y0, a0, b0, busy0, done0, pass0, or0;
    logic [3:0] tt0, mask0;
    // DUT 1: SETTLE=1
    logic rst1, start1, y1, a1, b1, busy1, done1, pass1, or1;
    logic [3:0] tt1, mask1;

    assign y0 = or0 ? (a0 | b0) : (a0 & b0);
    assign y1 = or1 ? (a1 | b1) : (a1 & b1);

    gate_seq_ctrl #(.SETTLE(2)) u_dut0 (
        .clk(clk), .rst(rst0), .start(start0), .exp_tt(tt0), .y(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0), .err_mask(mask0)
    );

    gate_seq_ctrl #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .exp_tt(tt1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1), .err_mask(mask1)
    );

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int unsigned settle, input int unsigned sc,
                                   input logic gor, input logic [3:0] tt);
        exp_t r;
        logic [1:0] v;
        logic yv;
        r.mask = '0;
        for (int i = 0; i < int'(NUM_VEC); i++) begin
            v  = 2'(i);
            yv = gor ? (v[1] | v[0]) : (v[1] & v[0]);
            r.mask[i] = yv ^ tt[i];
        end
        r.pass = (r.mask == 4'd0);
        r.cyc  = sc + 1 + NUM_VEC * (settle + 2);
        return r;
    endfunction

    // Done monitors: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("d0_spurious_done", 32'(done0), 32'(0));
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("d0_latency", cyc, e.cyc);
                check("d0_pass", 32'(pass0), 32'(e.pass));
                check("d0_err_mask", 32'(mask0), 32'(e.mask));
                check("d0_busy_at_done", 32'(busy0), 32'(0));
                check("d0_ab_at_done", 32'({a0, b0}), 32'(0));
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("d1_spurious_done", 32'(done1), 32'(0));
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("d1_latency", cyc, e.cyc);
                check("d1_pass", 32'(pass1), 32'(e.pass));
                check("d1_err_mask", 32'(mask1), 32'(e.mask));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the first sweep cycle.
    task automatic kick0(input logic gor, input logic [3:0] tt);
        or0    = gor;
        tt0    = tt;
        start0 = 1'b1;
        q0.push_back(model(2, cyc, gor, tt));
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic kick1(input logic gor, input logic [3:0] tt);
        or1    = gor;
        tt1    = tt;
        start1 = 1'b1;
        q1.push_back(model(1, cyc, gor, tt));
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic drain0();
        for (int i = 0; i < 200 && q0.size() != 0; i++) @(negedge clk);
        check("d0_drain_timeout", 32'(q0.size()), 32'(0));
        @(negedge clk);
    endtask

    task automatic drain1();
        for (int i = 0; i < 200 && q1.size() != 0; i++) @(negedge clk);
        check("d1_drain_timeout", 32'(q1.size()), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; start0 = 1'b0; tt0 = '0; or0 = 1'b1;
        rst1 = 1'b1; start1 = 1'b0; tt1 = '0; or1 = 1'b1;
        repeat (3) @(negedge clk);
        check("d0_reset_outs", 32'({a0, b0, busy0, done0, pass0, mask0}), 32'(0));
        check("d1_reset_outs", 32'({a1, b1, busy1, done1, pass1, mask1}), 32'(0));
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);

        // OR gate, matching table; vector order and hold time
        kick0(1'b1, 4'b1110);
        for (int j = 0; j < 16; j++) begin
            check("vec_ab", 32'({a0, b0}), 32'(j / 4));
            check("vec_busy", 32'(busy0), 32'(1));
            @(negedge clk);
        end
        drain0();
        check("idle_ab_after_done", 32'({a0, b0}), 32'(0));
        check("idle_busy_after_done", 32'(busy0), 32'(0));

        // AND gate against OR table; pass cleared on accept, results held afterwards
        kick0(1'b0, 4'b1110);
        check("pass_cleared_on_start", 32'(pass0), 32'(0));
        drain0();
        repeat (3) @(negedge clk);
        check("held_pass", 32'(pass0), 32'(0));
        check("held_err_mask", 32'(mask0), 32'(4'b0110));

        // start and exp_tt changes mid-sweep are ignored
        kick0(1'b1, 4'b1110);
        repeat (5) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        tt0    = 4'b0000;
        drain0();
        repeat (20) @(negedge clk);
        check("ignored_start_pass", 32'(pass0), 32'(1));
        check("ignored_start_mask", 32'(mask0), 32'(0));

        // reset during vector 2 aborts without done
        kick0(1'b0, 4'b1110);
        repeat (9) @(negedge clk);
        check("abort_at_idx2", 32'({a0, b0}), 32'(2));
        rst0 = 1'b1;
        q0.delete();
        @(negedge clk);
        rst0 = 1'b0;
        check("abort_outs_zero", 32'({a0, b0, busy0, done0, pass0, mask0}), 32'(0));
        repeat (20) @(negedge clk);
        kick0(1'b1, 4'b1110);
        drain0();
        check("post_abort_pass", 32'(pass0), 32'(1));

        // mixed gates and tables
        for (int n = 0; n < 6; n++) begin
            kick0(1'($urandom_range(0, 1)), 4'($urandom));
            drain0();
        end

        // SETTLE=1 instance
        kick1(1'b1, 4'b1110);
        drain1();
        check("d1_final_pass", 32'(pass1), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
